// File: rtl/id_jump_resolver_pkg.sv
// Shared constants for the ID-stage early-jump resolver: opcodes, early_jump encodings, FSM state codes.
package id_jump_resolver_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    EJ_NONE = 2'b00,
    EJ_JAL  = 2'b01,
    EJ_JALR = 2'b10
  } ej_e;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;

  function automatic logic f_is_jump(input logic [6:0] op);
    return (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

endpackage

// File: rtl/id_jump_resolver_fwd_mux.sv
// JALR rs1 forwarding select: EX > MEM > WB > register file, x0 never forwarded,
// MEM stage supplies load data when it holds a load.
module id_jalr_fwd_mux
  import id_jump_resolver_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
) (
  input  logic [REGISTER_ADDR_WIDTH-1:0] i_rs1,
  input  logic [REGISTER_ADDR_WIDTH-1:0] i_rd_ex,
  input  logic [REGISTER_ADDR_WIDTH-1:0] i_rd_mem,
  input  logic [REGISTER_ADDR_WIDTH-1:0] i_rd_wb,
  input  logic                           i_reg_write_ex,
  input  logic                           i_reg_write_mem,
  input  logic                           i_reg_write_wb,
  input  logic [6:0]                     i_opcode_mem,
  input  logic [DATA_WIDTH-1:0]          i_rd1,
  input  logic [DATA_WIDTH-1:0]          i_alu_res_ex,
  input  logic [DATA_WIDTH-1:0]          i_alu_res_mem,
  input  logic [DATA_WIDTH-1:0]          i_load_data_mem,
  input  logic [DATA_WIDTH-1:0]          i_result_wb,
  output logic [DATA_WIDTH-1:0]          o_base,
  output logic                           o_ex_match
);

  logic w_mem_match;
  logic w_wb_match;

  assign o_ex_match  = i_reg_write_ex  && (i_rd_ex  != '0) && (i_rd_ex  == i_rs1);
  assign w_mem_match = i_reg_write_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs1);
  assign w_wb_match  = i_reg_write_wb  && (i_rd_wb  != '0) && (i_rd_wb  == i_rs1);

  always_comb begin
    o_base = i_rd1;
    if (o_ex_match)
      o_base = i_alu_res_ex;
    else if (w_mem_match)
      o_base = (i_opcode_mem == OPC_LOAD) ? i_load_data_mem : i_alu_res_mem;
    else if (w_wb_match)
      o_base = i_result_wb;
  end

endmodule

// File: rtl/id_jump_resolver.sv
// ID-stage early-jump unit: JAL always, JALR only when JALR_EARLY_EN is defined.
// FSM stalls ID on a JALR load-use until the load data reaches MEM.
module id_jump_resolver
  import id_jump_resolver_pkg::*;
#(
  parameter int INST_ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int LOAD_WAIT_CYCLES    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_ID,
  input  logic                           flush_ID,
  input  logic [6:0]                     opcode_ID,
  input  logic [6:0]                     opcode_EX,
  input  logic [6:0]                     opcode_MEM,
  input  logic                           reg_write_EX,
  input  logic                           reg_write_MEM,
  input  logic                           reg_write_WB,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_WB,
  input  logic [INST_ADDR_WIDTH-1:0]     PC_ID,
  input  logic [DATA_WIDTH-1:0]          imm_ID,
  input  logic [DATA_WIDTH-1:0]          RD1D_ID,
  input  logic [DATA_WIDTH-1:0]          alu_res_EX,
  input  logic [DATA_WIDTH-1:0]          alu_res_MEM,
  input  logic [DATA_WIDTH-1:0]          load_data_MEM,
  input  logic [DATA_WIDTH-1:0]          result_WB,
  output logic [1:0]                     early_jump,
  output logic [INST_ADDR_WIDTH-1:0]     early_jump_target,
  output logic                           jump_stall_req
);

`ifdef JALR_EARLY_EN
  localparam logic JALR_EN = 1'b1;
`else
  localparam logic JALR_EN = 1'b0;
`endif

  localparam int CNT_W = (LOAD_WAIT_CYCLES > 1) ? $clog2(LOAD_WAIT_CYCLES) : 1;

  logic [1:0]                 r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_fired;
  logic                       r_rst_q;

  logic [1:0]                 w_state_n;
  logic [CNT_W-1:0]           w_cnt_n;
  logic                       w_fired_n;
  logic                       w_fire;
  logic [1:0]                 w_ej;
  logic                       w_stall;
  logic                       w_active;
  logic                       w_is_jal;
  logic                       w_is_jalr;
  logic                       w_is_jump;
  logic                       w_ex_match;
  logic                       w_load_use;
  logic [DATA_WIDTH-1:0]      w_base;
  logic [INST_ADDR_WIDTH-1:0] w_jal_tgt;
  logic [INST_ADDR_WIDTH-1:0] w_jalr_sum;

  id_jalr_fwd_mux #(
    .DATA_WIDTH          (DATA_WIDTH),
    .REGISTER_ADDR_WIDTH (REGISTER_ADDR_WIDTH)
  ) u_fwd (
    .i_rs1           (rs1_ID),
    .i_rd_ex         (rd_EX),
    .i_rd_mem        (rd_MEM),
    .i_rd_wb         (rd_WB),
    .i_reg_write_ex  (reg_write_EX),
    .i_reg_write_mem (reg_write_MEM),
    .i_reg_write_wb  (reg_write_WB),
    .i_opcode_mem    (opcode_MEM),
    .i_rd1           (RD1D_ID),
    .i_alu_res_ex    (alu_res_EX),
    .i_alu_res_mem   (alu_res_MEM),
    .i_load_data_mem (load_data_MEM),
    .i_result_wb     (result_WB),
    .o_base          (w_base),
    .o_ex_match      (w_ex_match)
  );

  // Outputs stay quiet in the reset cycle and the one after it.
  assign w_active   = !rst && !r_rst_q && !flush_ID;
  assign w_is_jal   = (opcode_ID == OPC_JAL);
  assign w_is_jalr  = (opcode_ID == OPC_JALR) && JALR_EN;
  assign w_is_jump  = w_is_jal || w_is_jalr;
  assign w_load_use = w_is_jalr && w_ex_match && (opcode_EX == OPC_LOAD);
  assign w_jal_tgt  = PC_ID + imm_ID[INST_ADDR_WIDTH-1:0];
  assign w_jalr_sum = w_base[INST_ADDR_WIDTH-1:0] + imm_ID[INST_ADDR_WIDTH-1:0];

  always_comb begin
    w_ej      = EJ_NONE;
    w_stall   = 1'b0;
    w_fire    = 1'b0;
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (!w_active) begin
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_use && !r_fired) begin
            w_stall   = 1'b1;
            w_cnt_n   = CNT_W'(LOAD_WAIT_CYCLES - 1);
            w_state_n = ST_LOAD_WAIT;
          end else if (w_is_jump && !r_fired) begin
            w_fire    = 1'b1;
            w_ej      = w_is_jal ? EJ_JAL : EJ_JALR;
            w_state_n = stall_ID ? ST_DONE : ST_IDLE;
          end else begin
            w_state_n = ST_IDLE;
          end
        end
        ST_LOAD_WAIT: begin
          if (!w_is_jalr) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
          end else if (r_cnt != '0) begin
            w_stall = 1'b1;
            w_cnt_n = r_cnt - CNT_W'(1);
          end else begin
            w_fire    = 1'b1;
            w_ej      = EJ_JALR;
            w_state_n = stall_ID ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!stall_ID || !w_is_jump)
            w_state_n = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  assign w_fired_n = w_active && stall_ID && (w_fire || (r_fired && w_is_jump));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fired <= 1'b0;
      r_rst_q <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_fired <= w_fired_n;
      r_rst_q <= 1'b0;
    end
  end

  assign early_jump        = w_ej;
  assign jump_stall_req    = w_stall && JALR_EN;
  assign early_jump_target = (w_ej == EJ_JAL)  ? w_jal_tgt :
                             (w_ej == EJ_JALR) ? {w_jalr_sum[INST_ADDR_WIDTH-1:1], 1'b0} :
                             '0;

endmodule

// File: tb/tb_id_jump_resolver.sv
// Scoreboard bench for id_jump_resolver: driver pushes model expectations, negedge monitor compares.
module tb_id_jump_resolver;

  localparam int LWC = 1;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;
  localparam logic [6:0] T_LOAD = 7'b0000011;
  localparam logic [6:0] T_ALU  = 7'b0110011;
  localparam logic [6:0] T_ADDI = 7'b0010011;

`ifdef JALR_EARLY_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk, rst, stall_ID, flush_ID;
  logic [6:0]  opcode_ID, opcode_EX, opcode_MEM;
  logic        reg_write_EX, reg_write_MEM, reg_write_WB;
  logic [4:0]  rs1_ID, rd_EX, rd_MEM, rd_WB;
  logic [31:0] PC_ID, imm_ID, RD1D_ID, alu_res_EX, alu_res_MEM, load_data_MEM, result_WB;
  logic [1:0]  early_jump;
  logic [31:0] early_jump_target;
  logic        jump_stall_req;

  id_jump_resolver #(
    .INST_ADDR_WIDTH(32), .DATA_WIDTH(32), .REGISTER_ADDR_WIDTH(5), .LOAD_WAIT_CYCLES(LWC)
  ) dut (
    .clk(clk), .rst(rst), .stall_ID(stall_ID), .flush_ID(flush_ID),
    .opcode_ID(opcode_ID), .opcode_EX(opcode_EX), .opcode_MEM(opcode_MEM),
    .reg_write_EX(reg_write_EX), .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
    .rs1_ID(rs1_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
    .PC_ID(PC_ID), .imm_ID(imm_ID), .RD1D_ID(RD1D_ID),
    .alu_res_EX(alu_res_EX), .alu_res_MEM(alu_res_MEM), .load_data_MEM(load_data_MEM),
    .result_WB(result_WB),
    .early_jump(early_jump), .early_jump_target(early_jump_target), .jump_stall_req(jump_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ej;
    logic [31:0] tgt;
    logic        stall;
    bit          tgt_zero;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_name = "init";
  bit    last_stall = 1'b0;

  // Reference model: instruction-level view of the ID slot.
  int m_wait  = -1;   // remaining stall cycles of a pending load-use JALR, -1 = none
  bit m_done  = 1'b0; // current ID instruction has already redirected
  bit m_blank = 1'b0; // first cycle after reset

  function automatic logic [31:0] ref_rs1();
    if (reg_write_EX && rd_EX != 0 && rd_EX == rs1_ID) return alu_res_EX;
    if (reg_write_MEM && rd_MEM != 0 && rd_MEM == rs1_ID)
      return (opcode_MEM == T_LOAD) ? load_data_MEM : alu_res_MEM;
    if (reg_write_WB && rd_WB != 0 && rd_WB == rs1_ID) return result_WB;
    return RD1D_ID;
  endfunction

  function automatic bit ref_load_use();
    return EN && opcode_ID == T_JALR && reg_write_EX && rd_EX != 0 &&
           rd_EX == rs1_ID && opcode_EX == T_LOAD;
  endfunction

  task automatic step();
    exp_t e;
    logic [31:0] jalr_t;
    e.ej = 2'd0; e.tgt = 32'd0; e.stall = 1'b0; e.tgt_zero = 1'b0;
    jalr_t = (ref_rs1() + imm_ID) & ~32'd1;
    if (rst) begin
      e.tgt_zero = 1'b1; m_wait = -1; m_done = 1'b0; m_blank = 1'b1;
    end else if (m_blank) begin
      e.tgt_zero = 1'b1; m_blank = 1'b0; m_wait = -1; m_done = 1'b0;
    end else if (flush_ID) begin
      m_wait = -1; m_done = 1'b0;
    end else if (m_wait >= 0) begin
      if (opcode_ID != T_JALR) m_wait = -1;
      else if (m_wait > 0) begin e.stall = 1'b1; m_wait--; end
      else begin e.ej = 2'd2; e.tgt = jalr_t; m_wait = -1; m_done = stall_ID; end
    end else if (m_done) begin
      if (!stall_ID || !(opcode_ID == T_JAL || opcode_ID == T_JALR)) m_done = 1'b0;
    end else if (ref_load_use()) begin
      e.stall = 1'b1; m_wait = LWC - 1;
    end else if (opcode_ID == T_JAL) begin
      e.ej = 2'd1; e.tgt = PC_ID + imm_ID; m_done = stall_ID;
    end else if (opcode_ID == T_JALR && EN) begin
      e.ej = 2'd2; e.tgt = jalr_t; m_done = stall_ID;
    end
    last_stall = e.stall;
    exp_q.push_back(e);
    name_q.push_back(cur_name);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    bit    ok;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      ok = (early_jump == e.ej) && (jump_stall_req == e.stall);
      if (e.ej != 2'd0) ok = ok && (early_jump_target == e.tgt);
      if (e.tgt_zero)   ok = ok && (early_jump_target == 32'd0);
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: ej got %0d want %0d, stall got %0d want %0d, tgt got %h want %h",
                 nm, early_jump, e.ej, jump_stall_req, e.stall, early_jump_target, e.tgt);
      end
    end
  end

  task automatic clr_pipe();
    stall_ID = 0; flush_ID = 0;
    opcode_EX = T_ALU; opcode_MEM = T_ALU;
    reg_write_EX = 0; reg_write_MEM = 0; reg_write_WB = 0;
    rd_EX = 0; rd_MEM = 0; rd_WB = 0;
    alu_res_EX = 32'h1111_0000; alu_res_MEM = 32'h2222_0000;
    load_data_MEM = 32'h3333_0000; result_WB = 32'h4444_0000;
  endtask

  task automatic nop();
    clr_pipe(); opcode_ID = T_ADDI; cur_name = "nop"; step();
  endtask

  task automatic rand_instr();
    case ($urandom_range(0, 3))
      0: opcode_ID = T_JAL;
      1, 2: opcode_ID = T_JALR;
      default: opcode_ID = T_ADDI;
    endcase
    rs1_ID = 5'($urandom_range(0, 3));
    PC_ID = $urandom; imm_ID = $urandom; RD1D_ID = $urandom;
  endtask

  task automatic rand_pipe();
    opcode_EX  = ($urandom_range(0, 1) == 0) ? T_LOAD : T_ALU;
    opcode_MEM = ($urandom_range(0, 1) == 0) ? T_LOAD : T_ALU;
    reg_write_EX  = ($urandom_range(0, 3) != 0);
    reg_write_MEM = ($urandom_range(0, 3) != 0);
    reg_write_WB  = ($urandom_range(0, 3) != 0);
    rd_EX  = 5'($urandom_range(0, 3));
    rd_MEM = 5'($urandom_range(0, 3));
    rd_WB  = 5'($urandom_range(0, 3));
    alu_res_EX = $urandom; alu_res_MEM = $urandom;
    load_data_MEM = $urandom; result_WB = $urandom;
  endtask

  initial begin
    bit new_i;
    rst = 1; clr_pipe();
    opcode_ID = T_JAL; rs1_ID = 0; PC_ID = 32'h100; imm_ID = 32'h20; RD1D_ID = 0;
    @(posedge clk); #1;

    cur_name = "reset_cycle";     step(); step();
    rst = 0; cur_name = "post_reset_quiet"; step();

    cur_name = "t1_jal";          step();
    nop();

    // forwarding priority and x0 guard
    clr_pipe(); opcode_ID = T_JALR; rs1_ID = 5; imm_ID = 32'h7; RD1D_ID = 32'hDEAD_0000;
    rd_EX = 5; reg_write_EX = 1; alu_res_EX = 32'h2000;
    rd_MEM = 5; reg_write_MEM = 1;
    cur_name = "t2_jalr_ex_fwd";  step();
    rd_EX = 6; opcode_MEM = T_LOAD; load_data_MEM = 32'h5000;
    cur_name = "jalr_mem_load";   step();
    opcode_MEM = T_ALU; alu_res_MEM = 32'h6001;
    cur_name = "jalr_mem_alu";    step();
    reg_write_MEM = 0; rd_WB = 5; reg_write_WB = 1; result_WB = 32'h7000;
    cur_name = "jalr_wb";         step();
    reg_write_WB = 0; rd_EX = 5; reg_write_EX = 0;
    cur_name = "jalr_regfile";    step();
    clr_pipe(); opcode_ID = T_JALR; rs1_ID = 0; rd_EX = 0; reg_write_EX = 1;
    alu_res_EX = 32'hFFFF; RD1D_ID = 0; imm_ID = 32'h40;
    cur_name = "t3_jalr_x0";      step();
    nop();

    // load-use then resolve from MEM
    clr_pipe(); opcode_ID = T_JALR; rs1_ID = 1; imm_ID = 4; RD1D_ID = 32'hBAD0;
    opcode_EX = T_LOAD; rd_EX = 1; reg_write_EX = 1;
    cur_name = "t4_load_use_stall"; step();
    clr_pipe(); opcode_MEM = T_LOAD; rd_MEM = 1; reg_write_MEM = 1; load_data_MEM = 32'h3000;
    cur_name = "t4_load_use_fire";  step();
    nop();

    // JAL held for three cycles fires once
    clr_pipe(); opcode_ID = T_JAL; PC_ID = 32'h400; imm_ID = 32'hFFFF_FFF0; stall_ID = 1;
    cur_name = "t5_jal_stall";    step(); step(); step();
    stall_ID = 0; cur_name = "t5_jal_release"; step();
    nop();

    // flush during LOAD_WAIT and during detection
    clr_pipe(); opcode_ID = T_JALR; rs1_ID = 2; imm_ID = 8;
    opcode_EX = T_LOAD; rd_EX = 2; reg_write_EX = 1;
    cur_name = "flush_setup";     step();
    clr_pipe(); flush_ID = 1; opcode_MEM = T_LOAD; rd_MEM = 2; reg_write_MEM = 1;
    cur_name = "flush_in_wait";   step();
    nop();
    clr_pipe(); opcode_ID = T_JALR; rs1_ID = 2; opcode_EX = T_LOAD; rd_EX = 2;
    reg_write_EX = 1; flush_ID = 1;
    cur_name = "flush_on_detect"; step();
    nop();

    // reset during LOAD_WAIT
    clr_pipe(); opcode_ID = T_JALR; rs1_ID = 3; opcode_EX = T_LOAD; rd_EX = 3; reg_write_EX = 1;
    cur_name = "rst_setup";       step();
    clr_pipe(); rst = 1; cur_name = "rst_in_wait"; step();
    rst = 0; cur_name = "rst_release"; step();
    nop();

    new_i = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (new_i) rand_instr();
      rand_pipe();
      stall_ID = ($urandom_range(0, 3) == 0);
      flush_ID = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      cur_name = "random";
      step();
      new_i = rst || flush_ID || (!stall_ID && !last_stall);
    end
    rst = 0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
